// File: rtl/sram_arb.sv
// Two-master arbiter/sequencer in front of a 2-bank x 4-byte-lane SRAM array.
// Optional grant/conflict statistics counters are enabled with SRAM_ARB_STATS_EN.
module sram_arb #(
  parameter int unsigned SRAM_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_HOLD        = 8
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  // master 0
  input  logic                       m0_req,
  input  logic                       m0_lock,
  input  logic                       m0_we,
  input  logic [SRAM_ADDR_WIDTH+2:0] m0_addr,
  input  logic [1:0]                 m0_size,
  input  logic [DATA_WIDTH-1:0]      m0_wdata,
  output logic                       m0_gnt,
  output logic [DATA_WIDTH-1:0]      m0_rdata,
  output logic                       m0_rvalid,
  // master 1
  input  logic                       m1_req,
  input  logic                       m1_lock,
  input  logic                       m1_we,
  input  logic [SRAM_ADDR_WIDTH+2:0] m1_addr,
  input  logic [1:0]                 m1_size,
  input  logic [DATA_WIDTH-1:0]      m1_wdata,
  output logic                       m1_gnt,
  output logic [DATA_WIDTH-1:0]      m1_rdata,
  output logic                       m1_rvalid,
  // SRAM array
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  output logic                       sram_we,
  output logic [3:0]                 bank0_cs,
  output logic [3:0]                 bank1_cs,
  input  logic [DATA_WIDTH-1:0]      bank0_rdata,
  input  logic [DATA_WIDTH-1:0]      bank1_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [15:0]                stat_gnt0_cnt,
  output logic [15:0]                stat_gnt1_cnt,
  output logic [15:0]                stat_conflict_cnt
`endif
);

  localparam int unsigned AW = SRAM_ADDR_WIDTH + 3;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e                     state_q, state_d;
  logic                       rr_last_q, rr_last_d;
  logic [HW-1:0]              hold_cnt_q, hold_cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       rd_vld_q, rd_id_q, rd_bank_q, rd_ill_q;

  logic                       win_vld, win_id;
  logic                       keep0, keep1;
  logic                       sel_lock, sel_we;
  logic [AW-1:0]              sel_addr;
  logic [1:0]                 sel_size;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [3:0]                 cs;
  logic [DATA_WIDTH-1:0]      rd_data;

  // Winner selection; the hresetn term keeps every output quiet while in reset.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    keep0   = (state_q == StOwn0) && m0_req && ((hold_cnt_q < HoldMax) || !m1_req);
    keep1   = (state_q == StOwn1) && m1_req && ((hold_cnt_q < HoldMax) || !m0_req);
    if (!hresetn) begin
      win_vld = 1'b0;
    end else if (keep0) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (keep1) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end else if (m0_req && m1_req) begin
      win_vld = 1'b1;
      win_id  = ~rr_last_q;
    end else if (m0_req) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (m1_req) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
  end

  assign m0_gnt = win_vld && !win_id;
  assign m1_gnt = win_vld && win_id;

  always_comb begin
    if (win_id) begin
      sel_lock  = m1_lock;
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_size  = m1_size;
      sel_wdata = m1_wdata;
    end else begin
      sel_lock  = m0_lock;
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_size  = m0_size;
      sel_wdata = m0_wdata;
    end
  end

  // Byte-lane chip selects; an illegal size selects no lane at all.
  always_comb begin
    cs = 4'b0000;
    unique case (sel_size)
      2'd0:    cs = 4'b0001 << sel_addr[1:0];
      2'd1:    cs = sel_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    cs = 4'b1111;
      default: cs = 4'b0000;
    endcase
  end

  assign bank0_cs   = (win_vld && !sel_addr[AW-1]) ? cs : 4'b0000;
  assign bank1_cs   = (win_vld &&  sel_addr[AW-1]) ? cs : 4'b0000;
  assign sram_we    = win_vld && sel_we;
  assign sram_addr  = win_vld ? sel_addr[AW-2:2] : addr_q;
  assign sram_wdata = win_vld ? sel_wdata : wdata_q;

  // Next state, round-robin pointer and lock hold counter.
  always_comb begin
    state_d    = StIdle;
    rr_last_d  = rr_last_q;
    hold_cnt_d = '0;
    if (win_vld) begin
      rr_last_d = win_id;
      if (sel_lock) begin
        state_d = win_id ? StOwn1 : StOwn0;
        if ((state_q == StOwn0 && !win_id) || (state_q == StOwn1 && win_id)) begin
          hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + HW'(1) : HoldMax;
        end else begin
          hold_cnt_d = HW'(1);
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= StIdle;
      rr_last_q  <= 1'b1;
      hold_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_vld_q   <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ill_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_vld_q   <= win_vld && !sel_we;
      if (win_vld) begin
        addr_q    <= sel_addr[AW-2:2];
        wdata_q   <= sel_wdata;
        rd_id_q   <= win_id;
        rd_bank_q <= sel_addr[AW-1];
        rd_ill_q  <= (sel_size == 2'd3);
      end
    end
  end

  // Read return: the SRAM output is already registered, so only steer and gate it.
  always_comb begin
    rd_data = '0;
    if (!rd_ill_q) begin
      rd_data = rd_bank_q ? bank1_rdata : bank0_rdata;
    end
  end

  assign m0_rvalid = rd_vld_q && !rd_id_q;
  assign m1_rvalid = rd_vld_q && rd_id_q;
  assign m0_rdata  = m0_rvalid ? rd_data : '0;
  assign m1_rdata  = m1_rvalid ? rd_data : '0;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] gnt0_cnt_q, gnt1_cnt_q, conf_cnt_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else if (stat_clr) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (m0_gnt && gnt0_cnt_q != 16'hFFFF) gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
      if (m1_gnt && gnt1_cnt_q != 16'hFFFF) gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
      if (m0_req && m1_req && conf_cnt_q != 16'hFFFF) conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign stat_gnt0_cnt     = gnt0_cnt_q;
  assign stat_gnt1_cnt     = gnt1_cnt_q;
  assign stat_conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Scoreboard bench for sram_arb: directed accesses per cycle, expected reads queued
// at grant time and compared when rvalid returns. Covers SRAM_ARB_STATS_EN when defined.
module tb_sram_arb;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        m0_req = 0, m0_lock = 0, m0_we = 0;
  logic [15:0] m0_addr = '0;
  logic [1:0]  m0_size = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [15:0] m1_addr = '0;
  logic [1:0]  m1_size = '0;
  logic [31:0] m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic [3:0]  bank0_cs, bank1_cs;
  logic [31:0] bank0_rdata = '0, bank1_rdata = '0;
`ifdef SRAM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic        clr_req = 1'b0;
  logic [15:0] stat_gnt0_cnt, stat_gnt1_cnt, stat_conflict_cnt;
`endif

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] env_mem [2][8192];

  always #5 hclk = ~hclk;

  sram_arb dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .m0_req      (m0_req),
    .m0_lock     (m0_lock),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_size     (m0_size),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rdata    (m0_rdata),
    .m0_rvalid   (m0_rvalid),
    .m1_req      (m1_req),
    .m1_lock     (m1_lock),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_size     (m1_size),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rdata    (m1_rdata),
    .m1_rvalid   (m1_rvalid),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_we     (sram_we),
    .bank0_cs    (bank0_cs),
    .bank1_cs    (bank1_cs),
    .bank0_rdata (bank0_rdata),
    .bank1_rdata (bank1_rdata)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_clr          (stat_clr),
    .stat_gnt0_cnt     (stat_gnt0_cnt),
    .stat_gnt1_cnt     (stat_gnt1_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  // Synchronous-read SRAM array model: byte-lane writes, registered read word.
  always @(posedge hclk) begin
    for (int l = 0; l < 4; l++) begin
      if (sram_we && bank0_cs[l]) env_mem[0][sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      if (sram_we && bank1_cs[l]) env_mem[1][sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
    end
    if (!sram_we && bank0_cs != 4'b0000) bank0_rdata <= env_mem[0][sram_addr];
    if (!sram_we && bank1_cs != 4'b0000) bank1_rdata <= env_mem[1][sram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic mreq_t mk(input logic lock, input logic we, input logic [15:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata);
    mreq_t m;
    m.req = 1'b1; m.lock = lock; m.we = we; m.addr = addr; m.size = size; m.wdata = wdata;
    return m;
  endfunction

  function automatic logic [3:0] exp_cs(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd2:    return 4'b1111;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      2'd0:    return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  // One cycle: drive both masters, check returns from the previous cycle and this grant.
  task automatic step(input mreq_t a, input mreq_t b, input int win);
    mreq_t       m;
    exp_t        e;
    logic [3:0]  c;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
    int          key;
    @(posedge hclk);
    #1;
    m0_req = a.req; m0_lock = a.lock; m0_we = a.we;
    m0_addr = a.addr; m0_size = a.size; m0_wdata = a.wdata;
    m1_req = b.req; m1_lock = b.lock; m1_we = b.we;
    m1_addr = b.addr; m1_size = b.size; m1_wdata = b.wdata;
`ifdef SRAM_ARB_STATS_EN
    stat_clr = clr_req;
`endif
    #3;
    rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.id == 0) begin rv0 = 1; rd0 = e.data; end
      else begin rv1 = 1; rd1 = e.data; end
    end
    check_eq("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, rv0});
    check_eq("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, rv1});
    check_eq("m0_rdata", m0_rdata, rd0);
    check_eq("m1_rdata", m1_rdata, rd1);
    check_eq("m0_gnt", {31'b0, m0_gnt}, {31'b0, win == 0});
    check_eq("m1_gnt", {31'b0, m1_gnt}, {31'b0, win == 1});
    if (win >= 0) begin
      m = (win == 0) ? a : b;
      c = exp_cs(m.size, m.addr[1:0]);
      key = int'(m.addr[15:2]);
      check_eq("bank0_cs", {28'b0, bank0_cs}, {28'b0, m.addr[15] ? 4'b0000 : c});
      check_eq("bank1_cs", {28'b0, bank1_cs}, {28'b0, m.addr[15] ? c : 4'b0000});
      check_eq("sram_we", {31'b0, sram_we}, {31'b0, m.we});
      check_eq("sram_addr", {19'b0, sram_addr}, {19'b0, m.addr[14:2]});
      if (m.we) begin
        check_eq("sram_wdata", sram_wdata, m.wdata);
        for (int l = 0; l < 4; l++) if (c[l]) ref_mem[key][8*l +: 8] = m.wdata[8*l +: 8];
      end else begin
        e.id = win;
        e.data = (m.size == 2'd3) ? 32'h0 : ref_mem[key];
        sb.push_back(e);
      end
    end else begin
      check_eq("idle_cs", {24'b0, bank1_cs, bank0_cs}, 32'h0);
      check_eq("idle_we", {31'b0, sram_we}, 32'h0);
    end
  endtask

  // Reset asserted late in the current cycle; pending reads are discarded.
  task automatic reset_dut();
    #2;
    hresetn = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    @(posedge hclk);
    #4;
    check_eq("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
    check_eq("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
    check_eq("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    check_eq("rst_cs_we", {23'b0, sram_we, bank1_cs, bank0_cs}, 32'h0);
    check_eq("rst_addr", {19'b0, sram_addr}, 32'h0);
    check_eq("rst_wdata", sram_wdata, 32'h0);
    sb.delete();
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    mreq_t idle;
    idle = '0;
    reset_dut();

    // Full-word write then read-back through bank 0.
    step(mk(0, 1, 16'h0004, 2, 32'hA5A5_1234), idle, 0);
    step(mk(0, 0, 16'h0004, 2, 32'h0), idle, 0);
    step(idle, idle, -1);

    // Bank 1 byte and halfword lanes.
    step(idle, mk(0, 1, 16'h8000, 2, 32'h1122_3344), 1);
    step(idle, mk(0, 1, 16'h8003, 0, 32'h7700_0000), 1);
    step(idle, mk(0, 0, 16'h8002, 1, 32'h0), 1);
    step(idle, idle, -1);

    // Continuous contention without lock: strict alternation from m0.
    reset_dut();
    for (int i = 0; i < 6; i++)
      step(mk(0, 0, 16'h0004, 2, 32'h0), mk(0, 0, 16'h8000, 2, 32'h0), i % 2);
    step(idle, idle, -1);

    // Lock held for MAX_HOLD grants, then forced handoff.
    for (int i = 0; i < 9; i++)
      step(mk(1, 1, 16'h0008, 2, 32'h1111_0000 + i), mk(0, 0, 16'h8000, 2, 32'h0),
           (i < 8) ? 0 : 1);
    step(idle, idle, -1);
    for (int i = 0; i < 12; i++) step(mk(1, 1, 16'h000C, 2, 32'h2222_0000 + i), idle, 0);
    step(mk(1, 1, 16'h000C, 2, 32'h3333_0000), mk(0, 0, 16'h8002, 1, 32'h0), 1);
    step(idle, idle, -1);

    // Illegal size: grant, no lanes, zero read data.
    step(idle, mk(0, 0, 16'h8000, 3, 32'h0), 1);
    step(idle, idle, -1);

    // Reset right after a read grant drops its return; first tie goes to m0.
    step(mk(0, 0, 16'h0004, 2, 32'h0), idle, 0);
    reset_dut();
    step(mk(0, 0, 16'h0004, 2, 32'h0), mk(0, 0, 16'h8000, 2, 32'h0), 0);
    step(idle, idle, -1);

`ifdef SRAM_ARB_STATS_EN
    reset_dut();
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, 16'h0190, 2, 32'h4444_0000 + i), mk(0, 1, 16'h8190, 2, 32'h5555_0000 + i),
           i % 2);
    clr_req = 1'b1;
    step(idle, idle, -1);
    check_eq("stat_conflict", {16'b0, stat_conflict_cnt}, 32'd10);
    check_eq("stat_gnt0", {16'b0, stat_gnt0_cnt}, 32'd5);
    check_eq("stat_gnt1", {16'b0, stat_gnt1_cnt}, 32'd5);
    clr_req = 1'b0;
    step(idle, idle, -1);
    check_eq("stat_conflict_clr", {16'b0, stat_conflict_cnt}, 32'd0);
    check_eq("stat_gnt0_clr", {16'b0, stat_gnt0_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
